fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the out-of-order core. It owns the architectural fetch PC, requests instructions from the icache one at a time, and drives the combinational next-PC predictor. It hands each fetched instruction, with its predicted successor, to the decoder, stalls on JALR until the target operand is resolved, and redirects on ROB flush.

## Interface
Parameters:
- RESET_PC, 32'h0, fetch PC after reset.

Ports:
- clk_in  in  1  core clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- ic_req_valid  out  1  icache request valid.
- ic_req_ready  in  1  icache accepts request.
- ic_req_addr  out  32  request address (= pc).
- ic_resp_valid  in  1  one-cycle response strobe.
- ic_resp_inst  in  32  fetched instruction.
- pp_pc  out  32  predictor now_pc.
- pp_inst  out  32  predictor now_inst.
- pp_op_type  out  7  predictor op_type.
- pp_imm  out  32  predictor imm, sign-extended.
- pp_val1  out  32  predictor val1.
- pp_next_pc  in  32  predictor next_pc.
- out_valid  out  1  instruction valid to decoder.
- out_ready  in  1  decoder/queue can accept.
- out_inst  out  32  instruction.
- out_pc  out  32  its PC.
- out_pred_pc  out  32  predicted next PC.
- jalr_val_valid  in  1  JALR rs1 value available.
- jalr_val  in  32  JALR rs1 value.
- flush_valid  in  1  ROB redirect.
- flush_pc  in  32  redirect target.

## Operation
- States: FETCH, WAIT_RESP, ISSUE, WAIT_JALR. Reset: state=FETCH, pc=RESET_PC, inst_reg=0, discard=0.
- FETCH: ic_req_valid=1, ic_req_addr=pc; on ic_req_ready -> WAIT_RESP.
- WAIT_RESP: on ic_resp_valid latch inst_reg -> ISSUE. At most one request is outstanding.
- Predecode of inst_reg[6:0]:
  - 1101111 (JAL): op_type=JAL, imm=J-imm.
  - 1100011 (branch): op_type=B_TYPE, imm=B-imm.
  - 1100111 (JALR): op_type=JALR, imm=I-imm.
  - Otherwise op_type=inst[6:0], imm=0.
- pp_pc=pc, pp_inst=inst_reg, pp_val1=jalr_val.
- ISSUE, non-JALR:
  - out_valid=1, out_inst=inst_reg, out_pc=pc, out_pred_pc=pp_next_pc.
  - On out_ready: pc<=pp_next_pc -> FETCH.
- ISSUE, JALR:
  - out_valid=1, out_pred_pc=pc+2.
  - On out_ready -> WAIT_JALR.
- WAIT_JALR: on jalr_val_valid, pc<=pp_next_pc (jalr_val+imm) -> FETCH.
- Flush, any state:
  - pc<=flush_pc -> FETCH. Flush overrides every other transition.
  - If flushed in WAIT_RESP, or in FETCH in the cycle the request is accepted, set discard.
- discard handling:
  - While discard=1, the next ic_resp_valid is dropped and discard clears.
  - FETCH does not assert ic_req_valid while discard=1.
- Arithmetic is 32-bit modulo; PC wrap from 32'hFFFFFFFE to 0 is legal.
- Outputs are registered or state-decoded. out_valid is gated combinationally by !flush_valid.

## Timing
- Minimum fetch-to-issue: request accepted cycle N, response N+k, out_valid at N+k+1.
- Issue handshake completes on the edge where out_valid & out_ready.
- Next request is earliest the cycle after the handshake: one instruction per 3 cycles with a 1-cycle icache.
- JALR: the PC updates on the edge where jalr_val_valid=1. ic_req_valid rises the next cycle.
- Flush: ic_req_valid with ic_req_addr=flush_pc the cycle after flush_valid, unless discard is pending.
- out_valid=0 in the flush cycle. A handshake in that cycle does not occur.
- Reset mid-operation: immediate return to reset values. ic_req_valid=0 and out_valid=0 while rst_n_in=0.

## Configuration
- FETCH_BRANCH_PREDICT_EN defined: branches drive op_type=B_TYPE (static taken, pc+imm).
- Not defined: branches drive op_type=7'b0, so the predictor returns fall-through pc+2. JAL and JALR are unaffected.

## Test plan
- Reset, RESET_PC=0x100, non-branch instruction 0x00000013:
  - ic_req_addr=0x100.
  - Issue with out_pc=0x100, out_pred_pc=0x102.
  - Next request at 0x102.
- JAL with imm=+0x20 at pc 0x200 -> out_pred_pc=0x220, next request 0x220.
- Branch with B-imm=-8 at 0x300:
  - With FETCH_BRANCH_PREDICT_EN: next request 0x2F8.
  - Without it: next request 0x302.
- JALR (imm=4) at 0x400:
  - Issued with out_pred_pc=0x402; no ic_req_valid while waiting.
  - jalr_val=0x1000 -> next request 0x1004.
- flush_valid (flush_pc=0x800) in WAIT_RESP:
  - The stale response is dropped and not issued.
  - Next request at 0x800 after the drop.
- out_ready=0 held 5 cycles in ISSUE: out_valid stays 1 with stable out_* and no new request. Then out_ready=1 advances the PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_ctrl                                                    |
// | Purpose  : Instruction-fetch sequencer; one outstanding icache request,  |
// |            predecode for the next-PC predictor, JALR stall, ROB flush.   |
// |            Optional macro FETCH_BRANCH_PREDICT_EN: static-taken branches.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic        ic_req_valid,
    input  logic        ic_req_ready,
    output logic [31:0] ic_req_addr,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_inst,
    output logic [31:0] pp_pc,
    output logic [31:0] pp_inst,
    output logic [6:0]  pp_op_type,
    output logic [31:0] pp_imm,
    output logic [31:0] pp_val1,
    input  logic [31:0] pp_next_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pred_pc,
    input  logic        jalr_val_valid,
    input  logic [31:0] jalr_val,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc
);

    localparam logic [1:0] c_st_fetch     = 2'd0;
    localparam logic [1:0] c_st_wait_resp = 2'd1;
    localparam logic [1:0] c_st_issue     = 2'd2;
    localparam logic [1:0] c_st_wait_jalr = 2'd3;

    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_discard;

    logic [6:0]  w_opcode;
    logic [6:0]  w_op_type;
    logic [31:0] w_imm;
    logic        w_is_jalr;
    logic        w_req_fire;
    logic        w_discard_set;

    assign w_opcode  = r_inst[6:0];
    assign w_is_jalr = (w_opcode == c_op_jalr);

    always_comb begin
        w_op_type = w_opcode;
        w_imm     = 32'h0;
        case (w_opcode)
            c_op_jal: w_imm = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12],
                               r_inst[20], r_inst[30:21], 1'b0};
            c_op_branch: begin
`ifdef FETCH_BRANCH_PREDICT_EN
                w_op_type = c_op_branch;
`else
                // Opcode hidden so the predictor falls through to pc+2.
                w_op_type = 7'b0;
`endif
                w_imm = {{19{r_inst[31]}}, r_inst[31], r_inst[7],
                         r_inst[30:25], r_inst[11:8], 1'b0};
            end
            c_op_jalr: w_imm = {{20{r_inst[31]}}, r_inst[31:20]};
            default: ;
        endcase
    end

    // Hold off new requests until the orphaned response of a flushed fetch returns.
    assign ic_req_valid  = rst_n_in && (r_state == c_st_fetch) && !r_discard;
    assign ic_req_addr   = r_pc;
    assign w_req_fire    = ic_req_valid && ic_req_ready;
    assign w_discard_set = flush_valid &&
                           (w_req_fire || ((r_state == c_st_wait_resp) && !ic_resp_valid));

    assign pp_pc      = r_pc;
    assign pp_inst    = r_inst;
    assign pp_op_type = w_op_type;
    assign pp_imm     = w_imm;
    assign pp_val1    = jalr_val;

    assign out_valid   = rst_n_in && (r_state == c_st_issue) && !flush_valid;
    assign out_inst    = r_inst;
    assign out_pc      = r_pc;
    assign out_pred_pc = w_is_jalr ? (r_pc + 32'd2) : pp_next_pc;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= c_st_fetch;
            r_pc      <= RESET_PC;
            r_inst    <= 32'h0;
            r_discard <= 1'b0;
        end else begin
            if (w_discard_set) begin
                r_discard <= 1'b1;
            end else if (ic_resp_valid) begin
                r_discard <= 1'b0;
            end

            if (flush_valid) begin
                r_pc    <= flush_pc;
                r_state <= c_st_fetch;
            end else begin
                case (r_state)
                    c_st_fetch: begin
                        if (w_req_fire) r_state <= c_st_wait_resp;
                    end
                    c_st_wait_resp: begin
                        if (ic_resp_valid && !r_discard) begin
                            r_inst  <= ic_resp_inst;
                            r_state <= c_st_issue;
                        end
                    end
                    c_st_issue: begin
                        if (out_ready) begin
                            if (w_is_jalr) begin
                                r_state <= c_st_wait_jalr;
                            end else begin
                                r_pc    <= pp_next_pc;
                                r_state <= c_st_fetch;
                            end
                        end
                    end
                    c_st_wait_jalr: begin
                        if (jalr_val_valid) begin
                            r_pc    <= pp_next_pc;
                            r_state <= c_st_fetch;
                        end
                    end
                    default: r_state <= c_st_fetch;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_ctrl                                                 |
// | Purpose  : Directed self-checking bench for fetch_ctrl with a simple     |
// |            next-PC predictor model and a hand-driven icache.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_req_valid;
    logic        ic_req_ready = 1'b0;
    logic [31:0] ic_req_addr;
    logic        ic_resp_valid = 1'b0;
    logic [31:0] ic_resp_inst = 32'h0;
    logic [31:0] pp_pc;
    logic [31:0] pp_inst;
    logic [6:0]  pp_op_type;
    logic [31:0] pp_imm;
    logic [31:0] pp_val1;
    logic [31:0] pp_next_pc;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pred_pc;
    logic        jalr_val_valid = 1'b0;
    logic [31:0] jalr_val = 32'h0;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_pc = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FETCH_BRANCH_PREDICT_EN
    localparam logic [31:0] c_branch_next = 32'h2F8;
`else
    localparam logic [31:0] c_branch_next = 32'h302;
`endif

    fetch_ctrl #(.RESET_PC(32'h100)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
        .pp_pc(pp_pc), .pp_inst(pp_inst), .pp_op_type(pp_op_type), .pp_imm(pp_imm),
        .pp_val1(pp_val1), .pp_next_pc(pp_next_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_pred_pc(out_pred_pc),
        .jalr_val_valid(jalr_val_valid), .jalr_val(jalr_val),
        .flush_valid(flush_valid), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    // External combinational next-PC predictor.
    always_comb begin
        case (pp_op_type)
            7'b1101111, 7'b1100011: pp_next_pc = pp_pc + pp_imm;
            7'b1100111:             pp_next_pc = pp_val1 + pp_imm;
            default:                pp_next_pc = pp_pc + 32'd2;
        endcase
    end

    // Request accepted, one-cycle response; ends sampled in ISSUE.
    task automatic do_fetch(input logic [31:0] inst);
        @(negedge clk); ic_req_ready = 1'b1;
        @(negedge clk); ic_req_ready = 1'b0; ic_resp_valid = 1'b1; ic_resp_inst = inst;
        @(negedge clk); ic_resp_valid = 1'b0; ic_resp_inst = 32'h0;
        #1;
    endtask

    task automatic handshake();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        @(negedge clk); flush_valid = 1'b1; flush_pc = pc;
        @(negedge clk); flush_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_cmp++; if (ic_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", ic_req_valid); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++; if (ic_req_valid !== 1'b1) begin n_bad++; $display("FAIL rst_req_valid_after: got %b want 1", ic_req_valid); end
        n_cmp++; if (ic_req_addr !== 32'h100) begin n_bad++; $display("FAIL rst_req_addr: got %h want 00000100", ic_req_addr); end
    endtask

    task automatic test_nonbranch();
        do_fetch(32'h00000013);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL nb_out_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_inst !== 32'h13) begin n_bad++; $display("FAIL nb_out_inst: got %h want 00000013", out_inst); end
        n_cmp++; if (out_pc !== 32'h100) begin n_bad++; $display("FAIL nb_out_pc: got %h want 00000100", out_pc); end
        n_cmp++; if (out_pred_pc !== 32'h102) begin n_bad++; $display("FAIL nb_pred_pc: got %h want 00000102", out_pred_pc); end
        n_cmp++; if (ic_req_valid !== 1'b0) begin n_bad++; $display("FAIL nb_no_req_in_issue: got %b want 0", ic_req_valid); end
        handshake();
        n_cmp++; if (ic_req_valid !== 1'b1) begin n_bad++; $display("FAIL nb_next_req_valid: got %b want 1", ic_req_valid); end
        n_cmp++; if (ic_req_addr !== 32'h102) begin n_bad++; $display("FAIL nb_next_addr: got %h want 00000102", ic_req_addr); end
    endtask

    task automatic test_jal();
        redirect(32'h200);
        do_fetch(32'h020000EF);
        n_cmp++; if (out_pred_pc !== 32'h220) begin n_bad++; $display("FAIL jal_pred_pc: got %h want 00000220", out_pred_pc); end
        n_cmp++; if (pp_imm !== 32'h20) begin n_bad++; $display("FAIL jal_imm: got %h want 00000020", pp_imm); end
        handshake();
        n_cmp++; if (ic_req_addr !== 32'h220) begin n_bad++; $display("FAIL jal_next_addr: got %h want 00000220", ic_req_addr); end
    endtask

    task automatic test_branch();
        redirect(32'h300);
        do_fetch(32'hFE000CE3);
        n_cmp++; if (out_pred_pc !== c_branch_next) begin n_bad++; $display("FAIL br_pred_pc: got %h want %h", out_pred_pc, c_branch_next); end
        handshake();
        n_cmp++; if (ic_req_addr !== c_branch_next) begin n_bad++; $display("FAIL br_next_addr: got %h want %h", ic_req_addr, c_branch_next); end
    endtask

    task automatic test_jalr();
        redirect(32'h400);
        do_fetch(32'h00408067);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL jalr_out_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_pred_pc !== 32'h402) begin n_bad++; $display("FAIL jalr_pred_pc: got %h want 00000402", out_pred_pc); end
        handshake();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (ic_req_valid !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL jalr_wait_idle[%0d]: req %b out %b want 0 0", i, ic_req_valid, out_valid); end
            @(negedge clk); #1;
        end
        @(negedge clk); jalr_val_valid = 1'b1; jalr_val = 32'h1000;
        @(negedge clk); jalr_val_valid = 1'b0; jalr_val = 32'h0; #1;
        n_cmp++; if (ic_req_valid !== 1'b1) begin n_bad++; $display("FAIL jalr_req_valid: got %b want 1", ic_req_valid); end
        n_cmp++; if (ic_req_addr !== 32'h1004) begin n_bad++; $display("FAIL jalr_next_addr: got %h want 00001004", ic_req_addr); end
    endtask

    task automatic test_flush_wait_resp();
        redirect(32'h500);
        @(negedge clk); ic_req_ready = 1'b1;
        @(negedge clk); ic_req_ready = 1'b0; flush_valid = 1'b1; flush_pc = 32'h800; #1;
        n_cmp++; if (ic_req_valid !== 1'b0) begin n_bad++; $display("FAIL fl_wait_req: got %b want 0", ic_req_valid); end
        @(negedge clk); flush_valid = 1'b0; #1;
        n_cmp++; if (ic_req_valid !== 1'b0) begin n_bad++; $display("FAIL fl_discard_blocks_req: got %b want 0", ic_req_valid); end
        @(negedge clk); ic_resp_valid = 1'b1; ic_resp_inst = 32'h00000013; #1;
        n_cmp++; if (ic_req_valid !== 1'b0) begin n_bad++; $display("FAIL fl_req_during_drop: got %b want 0", ic_req_valid); end
        @(negedge clk); ic_resp_valid = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_stale_issued: got %b want 0", out_valid); end
        n_cmp++; if (ic_req_valid !== 1'b1) begin n_bad++; $display("FAIL fl_req_after_drop: got %b want 1", ic_req_valid); end
        n_cmp++; if (ic_req_addr !== 32'h800) begin n_bad++; $display("FAIL fl_addr: got %h want 00000800", ic_req_addr); end
    endtask

    task automatic test_flush_issue();
        redirect(32'h600);
        do_fetch(32'h00000013);
        @(negedge clk); out_ready = 1'b1; flush_valid = 1'b1; flush_pc = 32'h900; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fi_out_valid_gated: got %b want 0", out_valid); end
        @(negedge clk); out_ready = 1'b0; flush_valid = 1'b0; #1;
        n_cmp++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h900) begin n_bad++; $display("FAIL fi_redirect: valid %b addr %h want 1 00000900", ic_req_valid, ic_req_addr); end
    endtask

    task automatic test_stall();
        redirect(32'h700);
        do_fetch(32'h00A00093);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h700 || out_inst !== 32'h00A00093 || out_pred_pc !== 32'h702 || ic_req_valid !== 1'b0)
                begin n_bad++; $display("FAIL stall[%0d]: valid %b pc %h inst %h pred %h req %b want 1 700 00a00093 702 0", i, out_valid, out_pc, out_inst, out_pred_pc, ic_req_valid); end
            @(negedge clk); #1;
        end
        handshake();
        n_cmp++; if (ic_req_addr !== 32'h702) begin n_bad++; $display("FAIL stall_next_addr: got %h want 00000702", ic_req_addr); end
    endtask

    task automatic test_wrap();
        redirect(32'hFFFFFFFE);
        do_fetch(32'h00000013);
        n_cmp++; if (out_pred_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pred_pc: got %h want 00000000", out_pred_pc); end
        handshake();
        n_cmp++; if (ic_req_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_next_addr: got %h want 00000000", ic_req_addr); end
    endtask

    task automatic test_reset_mid();
        redirect(32'hA00);
        do_fetch(32'h00000013);
        @(negedge clk); rst_n = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0 || ic_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_outputs: out %b req %b want 0 0", out_valid, ic_req_valid); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h100) begin n_bad++; $display("FAIL mid_rst_pc: valid %b addr %h want 1 00000100", ic_req_valid, ic_req_addr); end
    endtask

    initial begin
        test_reset();
        test_nonbranch();
        test_jal();
        test_branch();
        test_jalr();
        test_flush_wait_resp();
        test_flush_issue();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
